fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Controls the IF stage: drives the PC register's enable/select, issues in-order imem requests at the current PC,
//  buffers returned instructions for decode, and kills wrong-path fetches on EX-stage redirects.
//  Sits between the PC register, the instruction memory port and the IF/ID boundary.
// PARAMETERS
//  IBUF_DEPTH  4             instruction buffer entries, power of 2, >=2; also the cap on outstanding requests
//  RESET_PC    32'h0000_0000 PC of the first response after reset; must equal the PC register reset value
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous, active-high reset
//  pc_cur           in   32  current PC register value
//  pc_en            out  1   PC register load enable
//  pc_sel_target    out  1   1: PC loads pc_target; 0: PC loads pc_cur+4
//  pc_target        out  32  redirect target for PC register
//  redirect_valid   in   1   EX stage taken branch/jump this cycle
//  redirect_pc      in   32  redirect target
//  imem_req_valid   out  1   fetch request
//  imem_req_addr    out  32  request address (=pc_cur)
//  imem_req_ready   in   1   request accepted when valid&ready
//  imem_rsp_valid   in   1   in-order response; always accepted, no backpressure
//  imem_rsp_data    in   32  instruction word
//  if_valid         out  1   buffered instruction available to decode
//  if_instr         out  32  head instruction
//  if_pc            out  32  PC of head instruction
//  if_pc_plus_four  out  32  if_pc+4
//  dec_ready        in   1   decode consumes head when if_valid&dec_ready
// BEHAVIOUR
//  Reset: state=BOOT, outstanding=0, drop_cnt=0, ibuf empty, rsp_pc=RESET_PC, pc_target=0; all valid outputs and pc_en 0.
//  States: BOOT -> RUN unconditionally (no request in BOOT). RUN: normal fetch. REDIR_PEND: redirect waiting on stuck request.
//  Issue (RUN): imem_req_valid=1 iff outstanding+ibuf_count < IBUF_DEPTH and no redirect. Accept -> pc_en=1, sel=0, outstanding+1.
//  Once asserted, req valid/addr hold until accepted (including through REDIR_PEND).
//  Response: if drop_cnt>0 -> discard, drop_cnt-1; else push {rsp_pc,data} into ibuf, rsp_pc+=4. outstanding-1 either way.
//  Credit rule guarantees ibuf never overflows; a push into a full buffer is a design error (assertion).
//  Redirect in RUN, no stuck request: pc_en=1, sel=1, pc_target=redirect_pc; ibuf flushed; rsp_pc<=redirect_pc;
//   drop_cnt<=outstanding+accept-rsp_valid; the same-cycle response is discarded; if_valid forced 0 that cycle.
//  Redirect in RUN with imem_req_valid&!ready: latch target, flush, drop_cnt counts the stuck request too, -> REDIR_PEND.
//  REDIR_PEND: hold stale request; on accept pc_en=1, sel=1, pc_target=latched -> RUN. A new redirect overwrites latched
//   target, reflushes, recomputes drop_cnt.
//  Simultaneous push and pop on ibuf: both happen; count unchanged. Arithmetic on PCs wraps mod 2^32.
//  Latency: request accept -> earliest if_valid is the cycle after the response.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds outputs perf_redirects[31:0] (redirect_valid cycles) and perf_starve[31:0]
//   (cycles with dec_ready&!if_valid outside BOOT); both wrap, reset to 0.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  Package fetch_seq_pkg: fetch_state_t {FS_BOOT,FS_RUN,FS_REDIR_PEND}, XLEN=32, INSTR_BYTES=4.
//  Sub-module fetch_ibuf: sync FIFO {pc,instr}, push/pop/flush, count output, IBUF_DEPTH param; flush beats push.
// TESTING
//  1 Reset, RESET_PC=0x100, ready=1, 1-cycle memory -> if_pc 0x100,0x104,0x108 in order, pc_en pulses each accept.
//  2 dec_ready=0 forever, zero-latency memory -> at most 4 requests, ibuf fills to 4, imem_req_valid drops, no overflow.
//  3 Redirect to 0x200 with 2 outstanding -> both responses discarded, next if_pc=0x200, if_valid low in redirect cycle.
//  4 ready=0 with request pending, redirect to 0x300 -> addr held, state REDIR_PEND; ready=1 -> PC=0x300, stale rsp dropped.
//  5 Two redirects (0x400 then 0x500) back-to-back in REDIR_PEND -> only 0x500 path delivered.
//  6 rst asserted mid-stream with 3 outstanding -> all outputs 0 immediately, restart fetch at RESET_PC after BOOT.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// Shared types and constants for the IF-stage fetch sequencer and its instruction buffer.
package fetch_seq_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      FS_BOOT,
      FS_RUN,
      FS_REDIR_PEND
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } ibuf_entry_t;

   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(INSTR_BYTES);
   endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Synchronous FIFO of {pc, instr} entries between the imem response port and decode.
// Flush takes priority over a same-cycle push or pop.
module fetch_ibuf
   import fetch_seq_pkg::*;
#(
   parameter int IBUF_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               push,
   input  logic                               pop,
   input  logic                               flush,
   input  ibuf_entry_t                        push_entry,
   output ibuf_entry_t                        head_entry,
   output logic [$clog2(IBUF_DEPTH+1)-1:0]    count
);

   localparam int PTR_W = $clog2(IBUF_DEPTH);
   localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

   ibuf_entry_t      mem_q [IBUF_DEPTH];
   ibuf_entry_t      mem_d [IBUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop, full;

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      full     = (count_q == CNT_W'(IBUF_DEPTH));
      do_push  = push && !flush;
      do_pop   = pop && !flush && (count_q != '0);
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < IBUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_entry = mem_q[rd_ptr_q];
   assign count      = count_q;

   // The fetch credit scheme must never let a response land in a full buffer.
   ibuf_no_overflow_a: assert property (@(posedge clk) disable iff (rst)
      !(push && !flush && !pop && full));

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: PC enable/select, in-order imem requests, response buffering, redirect kill.
// Optional FETCH_PERF_CNT_EN adds perf_redirects / perf_starve counters.
//
// state         | meaning
// FS_BOOT       | one idle cycle after reset, no request issued
// FS_RUN        | normal fetch, requests issued while credits remain
// FS_REDIR_PEND | redirect seen while a request was stuck; waiting for it to be accepted
module fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int          IBUF_DEPTH = 4,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   output logic        pc_en,
   output logic        pc_sel_target,
   output logic [31:0] pc_target,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus_four,
   input  logic        dec_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_redirects,
   output logic [31:0] perf_starve
`endif
);

   localparam int CNT_W = $clog2(IBUF_DEPTH + 1);

   fetch_state_t     state_q, state_d;
   logic [CNT_W-1:0] outstanding_q, outstanding_d;
   logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [XLEN-1:0]  rsp_pc_q, rsp_pc_d;
   logic [XLEN-1:0]  target_q, target_d;
   logic             held_q, held_d;

   logic             credit_ok, redirect_act, accept, stuck;
   logic             ibuf_push, ibuf_pop, ibuf_flush;
   logic [CNT_W-1:0] ibuf_count;
   ibuf_entry_t      push_entry, head_entry;

   fetch_ibuf #(
      .IBUF_DEPTH (IBUF_DEPTH)
   ) u_ibuf (
      .clk        (clk),
      .rst        (rst),
      .push       (ibuf_push),
      .pop        (ibuf_pop),
      .flush      (ibuf_flush),
      .push_entry (push_entry),
      .head_entry (head_entry),
      .count      (ibuf_count)
   );

   always_comb begin
      state_d        = state_q;
      outstanding_d  = outstanding_q;
      drop_cnt_d     = drop_cnt_q;
      rsp_pc_d       = rsp_pc_q;
      target_d       = target_q;
      imem_req_valid = 1'b0;
      pc_en          = 1'b0;
      pc_sel_target  = 1'b0;
      pc_target      = target_q;
      ibuf_push      = 1'b0;
      ibuf_flush     = 1'b0;
      push_entry     = '{pc: rsp_pc_q, instr: imem_rsp_data};

      credit_ok    = ({1'b0, outstanding_q} + {1'b0, ibuf_count}) < (CNT_W+1)'(IBUF_DEPTH);
      redirect_act = redirect_valid && (state_q != FS_BOOT);

      case (state_q)
         FS_BOOT:       state_d = FS_RUN;
         FS_RUN:        imem_req_valid = held_q || (credit_ok && !redirect_valid);
         FS_REDIR_PEND: imem_req_valid = 1'b1;
         default:       state_d = FS_BOOT;
      endcase

      accept = imem_req_valid && imem_req_ready;
      stuck  = imem_req_valid && !imem_req_ready;
      held_d = stuck;

      if (accept) begin
         pc_en = 1'b1;
         if (state_q == FS_REDIR_PEND) begin
            pc_sel_target = 1'b1;
            state_d       = FS_RUN;
         end
      end

      // A redirect kills everything in flight, including a request still waiting to be accepted.
      if (redirect_act) begin
         ibuf_flush = 1'b1;
         target_d   = redirect_pc;
         rsp_pc_d   = redirect_pc;
         drop_cnt_d = outstanding_q + CNT_W'(imem_req_valid) - CNT_W'(imem_rsp_valid);
         if (stuck) begin
            state_d = FS_REDIR_PEND;
         end else begin
            pc_en         = 1'b1;
            pc_sel_target = 1'b1;
            pc_target     = redirect_pc;
            state_d       = FS_RUN;
         end
      end else if (imem_rsp_valid) begin
         if (drop_cnt_q != '0) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end else begin
            ibuf_push = 1'b1;
            rsp_pc_d  = next_pc(rsp_pc_q);
         end
      end

      outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);

      if_valid = (ibuf_count != '0) && !redirect_act;
      ibuf_pop = if_valid && dec_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= FS_BOOT;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
         rsp_pc_q      <= RESET_PC;
         target_q      <= '0;
         held_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
         rsp_pc_q      <= rsp_pc_d;
         target_q      <= target_d;
         held_q        <= held_d;
      end
   end

   assign imem_req_addr   = pc_cur;
   assign if_instr        = if_valid ? head_entry.instr : '0;
   assign if_pc           = if_valid ? head_entry.pc : '0;
   assign if_pc_plus_four = if_valid ? next_pc(head_entry.pc) : '0;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_redirects_q, perf_redirects_d;
   logic [31:0] perf_starve_q, perf_starve_d;

   always_comb begin
      perf_redirects_d = perf_redirects_q + (redirect_valid ? 32'd1 : 32'd0);
      perf_starve_d    = perf_starve_q +
                         ((dec_ready && !if_valid && (state_q != FS_BOOT)) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_redirects_q <= '0;
         perf_starve_q    <= '0;
      end else begin
         perf_redirects_q <= perf_redirects_d;
         perf_starve_q    <= perf_starve_d;
      end
   end

   assign perf_redirects = perf_redirects_q;
   assign perf_starve    = perf_starve_q;
`endif

endmodule
